// File: rtl/seven_seg_scan_driver_if.sv
// Signal bundle between a display controller (master) and the seven-segment
// scan driver (slave): load strobe, digit data, blanking and the scan outputs.
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_suppress;
    logic [3:0]              display_out;
    logic [NUM_DIGITS-1:0]   AN;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output load, value_in, blank_in, lz_suppress,
        input  display_out, AN, frame_done, pending
    );

    modport slave (
        input  load, value_in, blank_in, lz_suppress,
        output display_out, AN, frame_done, pending
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with double-buffered data,
// anti-ghost guard time, per-digit blanking and leading-zero suppression.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    seven_seg_scan_driver_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(GUARD_CYCLES);

    typedef enum logic {PH_GUARD, PH_SHOW} phase_e;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_value_q, active_value_q;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, active_blank_q;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              disp_q;
    logic                    frame_done_q;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    wrap;
    logic                    lit;
    phase_e                  phase;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    assign wrap      = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
    assign phase     = (cnt_q < GUARD_V) ? PH_GUARD : PH_SHOW;
    assign pending_d = wrap ? 1'b0 : (pending_q | bus.load);

    // Scan from the most significant digit down: a digit is a leading zero
    // while it and everything above it are zero. Digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero  = upper_zero && (active_value_q[4*i +: 4] == 4'd0);
            lz_blank[i] = bus.lz_suppress && (i != 0) && upper_zero;
        end
    end

    assign lit = (phase == PH_SHOW) && !active_blank_q[idx_q] && !lz_blank[idx_q];

    always_comb begin
        an_d = '1;
        if (lit) an_d[idx_q] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the data buffers are ordinary flops, not a RAM, so resetting them costs nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_value_q <= '0;
            shadow_blank_q <= '0;
            active_value_q <= '0;
            active_blank_q <= '0;
            pending_q      <= 1'b0;
            an_q           <= '1;
            disp_q         <= 4'd0;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            disp_q       <= active_value_q[{idx_q, 2'b00} +: 4];
            frame_done_q <= wrap;
            pending_q    <= pending_d;
            if (bus.load) begin
                shadow_value_q <= bus.value_in;
                shadow_blank_q <= bus.blank_in;
            end
            // A load coinciding with the wrap goes straight to the active copy.
            if (wrap && (pending_q || bus.load)) begin
                active_value_q <= bus.load ? bus.value_in : shadow_value_q;
                active_blank_q <= bus.load ? bus.blank_in : shadow_blank_q;
            end
        end
    end

    assign bus.AN          = an_q;
    assign bus.display_out = disp_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.pending     = pending_q;
endmodule
